uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares one RS232 serial line between up to 16 requesters that each produce a 12-bit measurement word, such as distance sensors or status counters. A round-robin arbiter grants one requester at a time and latches its word. The block sends the word as two UART frames, the second tagged with the source ID so the host can demultiplex. It sits between the measurement blocks and the board's TX pin.

## Interface
- `N_SRC`, default 2: number of requesters, 1..16.
- `DATA_W`, default 12: word width, fixed at 12. Other values are illegal.
- `BAUD_DIV`, default 5208: clock cycles per bit time (9600 baud at 50 MHz). Simulation uses 5.
- `clk` input, 1: system clock. All logic on the rising edge.
- `n_rst` input, 1: asynchronous, active-low reset.
- `req` input, `N_SRC`: level request per source. Held until `ack`.
- `data` input, `N_SRC*12`: source i word is `data[12*i+11:12*i]`. Must be valid while `req[i]` is high.
- `ack` output, `N_SRC`: one-cycle grant pulse. The word is latched in the same cycle.
- `tx` output, 1: serial line, idle high.
- `busy` output, 1: high from the `ack` cycle until the end of the final gap.

## Operation
- Reset values: `tx`=1, `ack`=0, `busy`=0, state IDLE, round-robin pointer=0, baud counter=0.
- IDLE: if any `req` bit is high, grant the first set bit searching upward from the pointer, modulo `N_SRC`.
  - In the grant cycle: pulse `ack[g]`, latch `data` of source g, latch g, set pointer to g+1 (mod `N_SRC`), go to SEND_LO.
  - If no request is high, stay in IDLE with `tx`=1.
- SEND_LO: one frame with payload `word[7:0]`.
- GAP1: one bit time with `tx`=1.
- SEND_HI: one frame with payload `{g[3:0], word[11:8]}`.
- GAP2: one bit time with `tx`=1, then IDLE.
- Frame layout: start bit 0, 8 data bits LSB first, even parity (XOR of the 8 payload bits, only under the macro), stop bit 1.
- `req` is sampled only in IDLE:
  - A request raised and dropped while `busy` is never seen.
  - `data` changes after `ack` do not affect the word in flight.
- The requester must drop `req[g]` within one cycle of `ack[g]`. Otherwise it is re-granted only after the other pending sources have been served.
- Reset asserted mid-frame: `tx` goes to 1 at once (asynchronous) and the word is discarded. There is no resend after reset release.

## Timing
- The grant happens in the first IDLE cycle with any `req` high. `tx` drives the start bit from the cycle after `ack`.
- Every bit lasts exactly `BAUD_DIV` cycles. The baud counter restarts at 0 at each frame start; there is no free-running phase.
- Word duration, with parity: 11+1+11+1 = 24 bit times, i.e. 24·`BAUD_DIV` cycles from the cycle after `ack` to the return to IDLE. Without parity: 22 bit times.
- `busy` falls in the cycle IDLE is re-entered. A pending `req` can be granted in that same cycle, so back-to-back words have no extra dead cycle.

## Configuration
- `UART_TX_SCHED_PARITY_EN`
  - Defined: 11-bit frames with even parity.
  - Undefined: 10-bit frames (8N1). The parity bit is omitted and the word takes 22 bit times.
- The host decoder must be built with the same setting.

## Structure
- Package `uart_tx_sched_pkg` holds:
  - the state enum (IDLE, SEND_LO, GAP1, SEND_HI, GAP2);
  - `FRAME_BITS` (11 or 10, set by the macro) and `SRC_ID_W`=4;
  - an even-parity function.
- Sub-module `uart_byte_tx`:
  - handles one frame: `start`/8-bit `byte` in, `done` pulse out, plus `tx`.
  - owns the baud counter and bit index.
- The scheduler contains the arbiter, word latch, gap timing and state machine.

## Test plan
All scenarios use `BAUD_DIV`=5 and `N_SRC`=2 (scenario 1 also repeats with `N_SRC`=1 to cover the minimum).
1. `req`=01, `data[11:0]`=12'hA5C:
   - `ack`=01 in the next cycle.
   - Frame 1 bits: 0, 0,0,1,1,1,0,1,0, parity 0, 1.
   - 5 cycles high.
   - Frame 2 payload 8'h0A: 0, 0,1,0,1,0,0,0,0, parity 0, 1.
   - `busy` lasts 121 cycles (the `ack` cycle plus 24·5 bit cycles).
2. `req`=11 held (each source re-raises after its `ack`), words 12'h111 and 12'h222:
   - Grants alternate 0,1,0,1.
   - Second-frame payloads alternate 8'h01 and 8'h12.
   - No idle cycle between words.
3. `data`=12'h001 from source 0: frame 1 parity bit = 1, frame 2 payload 8'h00 with parity 0.
4. Assert `n_rst` low during the 4th data bit of frame 1: `tx`=1 and `busy`=0 at once. After release with no `req`, `tx` stays 1 for at least 50 cycles.
5. While `busy` serving source 0, pulse `req[1]` for 3 cycles and then drop it: no `ack[1]` and only one word on `tx`.
6. Build without `UART_TX_SCHED_PARITY_EN`, data 12'hA5C:
   - Frames are 10 bits with no parity bit.
   - The return to IDLE comes 110 cycles after `ack`.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART word scheduler; frame length follows UART_TX_SCHED_PARITY_EN.
// No logic of its own: state encoding, frame size and the parity helper.
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_LO,
        GAP1,
        SEND_HI,
        GAP2
    } state_t;

`ifdef UART_TX_SCHED_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam int SRC_ID_W = 4;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// One UART frame (start, 8 data LSB first, parity under UART_TX_SCHED_PARITY_EN, stop).
// Latency: start bit on tx the cycle after start; done pulses in the last cycle of the stop bit.
// Backpressure: none; start is only legal while no frame is in progress.
module uart_byte_tx
    import uart_tx_sched_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [7:0] payload,
    output logic       done,
    output logic       tx
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CNT_W-1:0]      baud_cnt;
    logic [3:0]            bit_idx;
    logic [FRAME_BITS-2:0] shreg;
    logic                  active;
    logic [FRAME_BITS-1:0] frame;
    logic                  bit_end;

    always_comb begin
`ifdef UART_TX_SCHED_PARITY_EN
        frame = {1'b1, even_parity(payload), payload, 1'b0};
`else
        frame = {1'b1, payload, 1'b0};
`endif
    end

    assign bit_end = active && (baud_cnt == CNT_W'(BAUD_DIV - 1));
    assign done    = bit_end && (bit_idx == 4'(FRAME_BITS - 1));

    // tx is registered so the pin never glitches; idle and gaps both read as 1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
            tx       <= 1'b1;
        end else if (start) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= frame[0];
            shreg    <= frame[FRAME_BITS-1:1];
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (done) begin
                active <= 1'b0;
                tx     <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[FRAME_BITS-2:1]};
            end
        end else if (active) begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin share of one UART TX line between N_SRC 12-bit word sources (UART_TX_SCHED_PARITY_EN adds parity).
// Latency: ack in the first IDLE cycle with a request, start bit the next cycle; word = 2 frames + 2 gap bits.
// Backpressure: req is level-held until ack and only sampled in IDLE; busy marks the word in flight.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int N_SRC    = 2,
    parameter int DATA_W   = 12,
    parameter int BAUD_DIV = 5208
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [N_SRC-1:0]        req,
    input  logic [N_SRC*DATA_W-1:0] data,
    output logic [N_SRC-1:0]        ack,
    output logic                    tx,
    output logic                    busy
);

    localparam int ID1_W = SRC_ID_W + 1;
    localparam int GAP_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    state_t              state, state_nxt;
    logic [SRC_ID_W-1:0] ptr, gnt_id, src_id;
    logic [ID1_W-1:0]    sum;
    logic [N_SRC-1:0]    rot;
    logic                gnt_vld, grant;
    logic [DATA_W-1:0]   gnt_word, word;
    logic [GAP_W-1:0]    gap_cnt;
    logic                in_gap, gap_end;
    logic                start, done;
    logic [7:0]          payload;

    // Rotating the doubled request vector puts the pointer's source at bit 0.
    assign rot = N_SRC'({req, req} >> ptr);

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        gnt_word = '0;
        sum      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!gnt_vld && rot[k]) begin
                gnt_vld = 1'b1;
                sum     = {1'b0, ptr} + ID1_W'(k);
                if (sum >= ID1_W'(N_SRC)) begin
                    sum = sum - ID1_W'(N_SRC);
                end
                gnt_id = sum[SRC_ID_W-1:0];
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_id == SRC_ID_W'(i)) begin
                gnt_word = data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant = (state == IDLE) && gnt_vld;
    assign busy  = (state != IDLE) || grant;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            ack[i] = grant && (gnt_id == SRC_ID_W'(i));
        end
    end

    assign in_gap  = (state == GAP1) || (state == GAP2);
    assign gap_end = in_gap && (gap_cnt == GAP_W'(BAUD_DIV - 1));

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        payload   = word[7:0];
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = SEND_LO;
                    start     = 1'b1;
                    payload   = gnt_word[7:0];
                end
            end
            SEND_LO: if (done) state_nxt = GAP1;
            // The high frame is launched on the last gap cycle so its start bit follows the gap directly.
            GAP1: begin
                if (gap_end) begin
                    state_nxt = SEND_HI;
                    start     = 1'b1;
                    payload   = {src_id, word[DATA_W-1:8]};
                end
            end
            SEND_HI: if (done) state_nxt = GAP2;
            GAP2:    if (gap_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            ptr     <= '0;
            word    <= '0;
            src_id  <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                word   <= gnt_word;
                src_id <= gnt_id;
                ptr    <= (gnt_id == SRC_ID_W'(N_SRC - 1)) ? '0 : gnt_id + SRC_ID_W'(1);
            end
            if (in_gap && !gap_end) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .clk    (clk),
        .n_rst  (n_rst),
        .start  (start),
        .payload(payload),
        .done   (done),
        .tx     (tx)
    );

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with BAUD_DIV=5, N_SRC=2 plus an N_SRC=1 instance.
// Expected line levels come from hand-computed payloads framed by a small line builder.
module tb_uart_tx_scheduler;

`ifdef UART_TX_SCHED_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int BD = 5;
    localparam int NB = 2 * FB + 2;
    localparam int WC = NB * BD;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [1:0]  req;
    logic [23:0] data;
    logic [1:0]  ack;
    logic        tx, busy;
    logic        req1;
    logic [11:0] data1;
    logic        ack1;
    logic        tx1, busy1;

    int total = 0;
    int bad   = 0;

    logic       wave  [0:255];
    logic       bwave [0:255];
    logic [1:0] awave [0:255];
    logic [23:0] exp_line;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_SRC(2), .DATA_W(12), .BAUD_DIV(BD)) dut2 (
        .clk(clk), .n_rst(n_rst), .req(req), .data(data),
        .ack(ack), .tx(tx), .busy(busy)
    );

    uart_tx_scheduler #(.N_SRC(1), .DATA_W(12), .BAUD_DIV(BD)) dut1 (
        .clk(clk), .n_rst(n_rst), .req(req1), .data(data1),
        .ack(ack1), .tx(tx1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        req   = 2'b00;
        req1  = 1'b0;
        #1;
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    task automatic record(input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            wave[i]  = tx;
            bwave[i] = busy;
            awave[i] = ack;
            tick();
        end
    endtask

    function automatic logic [23:0] build_line(input logic [7:0] lo, input logic [7:0] hi);
        logic [23:0] l;
        logic [7:0]  b;
        int          p;
        l = '1;
        p = 0;
        for (int f = 0; f < 2; f++) begin
            b = (f == 0) ? lo : hi;
            l[p] = 1'b0;
            p++;
            for (int j = 0; j < 8; j++) begin
                l[p] = b[j];
                p++;
            end
`ifdef UART_TX_SCHED_PARITY_EN
            l[p] = ^b;
            p++;
`endif
            l[p] = 1'b1;
            p++;
            l[p] = 1'b1;
            p++;
        end
        return l;
    endfunction

    task automatic test_reset();
        n_rst = 1'b0;
        req   = 2'b00;
        req1  = 1'b0;
        data  = '0;
        data1 = '0;
        #12;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || ack !== 2'b00) begin
            bad++;
            $display("FAIL reset2 tx=%b busy=%b ack=%b want 1 0 00", tx, busy, ack);
        end
        total++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || ack1 !== 1'b0) begin
            bad++;
            $display("FAIL reset1 tx=%b busy=%b ack=%b want 1 0 0", tx1, busy1, ack1);
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int blen;
        do_reset();
        tick();
        req  = 2'b01;
        data = {12'h000, 12'hA5C};
        #1;
        total++;
        if (ack !== 2'b01 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_ack ack=%b busy=%b want 01 1", ack, busy);
        end
        tick();
        req  = 2'b00;
        data = {12'h000, 12'hFFF};
        #1;
        total++;
        if (ack !== 2'b00) begin
            bad++;
            $display("FAIL single_ack_pulse ack=%b want 00", ack);
        end
        record(0, WC);
        exp_line = build_line(8'h5C, 8'h0A);
        blen = 1;
        for (int i = 0; i < WC; i++) begin
            total++;
            if (wave[i] !== exp_line[i / BD]) begin
                bad++;
                $display("FAIL single_line cyc=%0d tx=%b want %b", i + 1, wave[i], exp_line[i / BD]);
            end
            if (bwave[i] === 1'b1) blen++;
        end
        total++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            bad++;
            $display("FAIL single_idle busy=%b tx=%b want 0 1", busy, tx);
        end
        total++;
        if (blen !== WC + 1) begin
            bad++;
            $display("FAIL single_busy_len got=%0d want %0d", blen, WC + 1);
        end
    endtask

    task automatic test_single_min();
        do_reset();
        tick();
        req1  = 1'b1;
        data1 = 12'hA5C;
        #1;
        total++;
        if (ack1 !== 1'b1) begin
            bad++;
            $display("FAIL min_ack ack=%b want 1", ack1);
        end
        tick();
        req1 = 1'b0;
        #1;
        exp_line = build_line(8'h5C, 8'h0A);
        for (int i = 0; i < WC; i++) begin
            total++;
            if (tx1 !== exp_line[i / BD] || busy1 !== 1'b1) begin
                bad++;
                $display("FAIL min_line cyc=%0d tx=%b busy=%b want %b 1", i + 1, tx1, busy1, exp_line[i / BD]);
            end
            tick();
        end
        total++;
        if (busy1 !== 1'b0) begin
            bad++;
            $display("FAIL min_idle busy=%b want 0", busy1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] lo_tab [0:1];
        logic [7:0] hi_tab [0:1];
        int g;
        lo_tab[0] = 8'h11;
        lo_tab[1] = 8'h22;
        hi_tab[0] = 8'h01;
        hi_tab[1] = 8'h12;
        do_reset();
        tick();
        req  = 2'b11;
        data = {12'h222, 12'h111};
        #1;
        for (int w = 0; w < 4; w++) begin
            g = w % 2;
            total++;
            if (ack !== 2'(1 << g) || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_grant word=%0d ack=%b busy=%b want %b 1", w, ack, busy, 2'(1 << g));
            end
            tick();
            if (w == 3) req = 2'b00;
            else        req[g] = 1'b0;
            #1;
            record(0, 10);
            if (w < 2) req[g] = 1'b1;
            record(10, WC - 10);
            exp_line = build_line(lo_tab[g], hi_tab[g]);
            for (int i = 0; i < WC; i++) begin
                total++;
                if (wave[i] !== exp_line[i / BD] || bwave[i] !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_line word=%0d cyc=%0d tx=%b busy=%b want %b 1",
                             w, i + 1, wave[i], bwave[i], exp_line[i / BD]);
                end
            end
        end
        total++;
        if (busy !== 1'b0 || ack !== 2'b00) begin
            bad++;
            $display("FAIL b2b_end busy=%b ack=%b want 0 00", busy, ack);
        end
    endtask

    task automatic test_parity_one();
        do_reset();
        tick();
        req  = 2'b01;
        data = {12'h000, 12'h001};
        #1;
        tick();
        req = 2'b00;
        #1;
        record(0, WC);
        exp_line = build_line(8'h01, 8'h00);
        for (int i = 0; i < WC; i++) begin
            total++;
            if (wave[i] !== exp_line[i / BD]) begin
                bad++;
                $display("FAIL par_line cyc=%0d tx=%b want %b", i + 1, wave[i], exp_line[i / BD]);
            end
        end
`ifdef UART_TX_SCHED_PARITY_EN
        total++;
        if (wave[9 * BD + 2] !== 1'b1) begin
            bad++;
            $display("FAIL par_bit_lo tx=%b want 1", wave[9 * BD + 2]);
        end
        total++;
        if (wave[(FB + 1 + 9) * BD + 2] !== 1'b0) begin
            bad++;
            $display("FAIL par_bit_hi tx=%b want 0", wave[(FB + 1 + 9) * BD + 2]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        req  = 2'b01;
        data = {12'h000, 12'h0A5};
        #1;
        tick();
        req = 2'b00;
        #1;
        record(0, 22);
        total++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre tx=%b busy=%b want 0 1", tx, busy);
        end
        n_rst = 1'b0;
        #1;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async tx=%b busy=%b want 1 0", tx, busy);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            total++;
            if (tx !== 1'b1 || busy !== 1'b0 || ack !== 2'b00) begin
                bad++;
                $display("FAIL rstmid_quiet cyc=%0d tx=%b busy=%b ack=%b want 1 0 00", i, tx, busy, ack);
            end
        end
    endtask

    task automatic test_ignore_pulse();
        do_reset();
        tick();
        req  = 2'b01;
        data = {12'h7FF, 12'h3C7};
        #1;
        tick();
        req = 2'b00;
        #1;
        record(0, 10);
        req[1] = 1'b1;
        record(10, 3);
        req[1] = 1'b0;
        record(13, WC - 13);
        exp_line = build_line(8'hC7, 8'h03);
        for (int i = 0; i < WC; i++) begin
            total++;
            if (wave[i] !== exp_line[i / BD] || awave[i] !== 2'b00) begin
                bad++;
                $display("FAIL ignore_line cyc=%0d tx=%b ack=%b want %b 00",
                         i + 1, wave[i], awave[i], exp_line[i / BD]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            total++;
            if (tx !== 1'b1 || ack !== 2'b00 || busy !== 1'b0) begin
                bad++;
                $display("FAIL ignore_after cyc=%0d tx=%b ack=%b busy=%b want 1 00 0", i, tx, ack, busy);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_single_min();
        test_back_to_back();
        test_parity_one();
        test_reset_mid();
        test_ignore_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
